sndreg_snoop: RTL and testbench

SNDREG_SNOOP -- requirements
Module: sndreg_snoop

---
 rtl/sndreg_snoop.sv | 182 ++++++++++++++++++
 tb/tb_sndreg_snoop.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sndreg_snoop.sv
// sndreg_snoop: passive snooper for DMG sound-channel-1 register writes.
//
// Watches the asynchronous DMG CPU bus, filters the write strobe, and mirrors
// NR11..NR14 and NR52 into registered outputs in the clk_8m domain.
//
// Ports
//   clk_8m      in   8 MHz system clock, rising edge
//   rst         in   synchronous active-high reset
//   bus_addr    in   [15:0] CPU address bus (async)
//   bus_data    in   [7:0]  CPU data bus (async)
//   bus_wr_n    in   CPU write strobe, active low (async)
//   freq        out  [10:0] {NR14[2:0], NR13[7:0]}
//   start_sound out  one-cycle channel-1 trigger
//   duty        out  [1:0] NR11[7:6]
//   env_init    out  [3:0] NR12[7:4]
//   env_dir     out  NR12[3]
//   env_pace    out  [2:0] NR12[2:0]
//   snd_on      out  NR52[7], master sound enable
module sndreg_snoop #(
  parameter int unsigned FILT_MIN = 2
) (
  input  logic        clk_8m,
  input  logic        rst,
  input  logic [15:0] bus_addr,
  input  logic [7:0]  bus_data,
  input  logic        bus_wr_n,
  output logic [10:0] freq,
  output logic        start_sound,
  output logic [1:0]  duty,
  output logic [3:0]  env_init,
  output logic        env_dir,
  output logic [2:0]  env_pace,
  output logic        snd_on
);

  localparam logic [2:0]  FiltMin  = 3'(FILT_MIN);
  localparam logic [15:0] AddrNr11 = 16'hFF11;
  localparam logic [15:0] AddrNr12 = 16'hFF12;
  localparam logic [15:0] AddrNr13 = 16'hFF13;
  localparam logic [15:0] AddrNr14 = 16'hFF14;
  localparam logic [15:0] AddrNr52 = 16'hFF26;

  // Two-flop synchronizers. The multi-bit buses may be sampled mid-transition,
  // but they are stable throughout a real low phase, and only the last
  // low-phase sample is ever committed.
  logic [15:0] r_addr_s1, r_addr_s2;
  logic [7:0]  r_data_s1, r_data_s2;
  logic        r_wr_n_s1, r_wr_n_s2;

  // Strobe filter and last-low-phase hold register.
  logic [2:0]  r_cnt;
  logic [15:0] r_hold_addr;
  logic [7:0]  r_hold_data;

  // Mirrored register state.
  logic [10:0] r_freq;
  logic        r_start;
  logic [1:0]  r_duty;
  logic [3:0]  r_env_init;
  logic        r_env_dir;
  logic [2:0]  r_env_pace;
  logic        r_snd_on;

  logic        w_commit;
  logic [10:0] w_freq_d;
  logic        w_start_d;
  logic [1:0]  w_duty_d;
  logic [3:0]  w_env_init_d;
  logic        w_env_dir_d;
  logic [2:0]  w_env_pace_d;
  logic        w_snd_on_d;
  logic        w_dac_on;

  always_ff @(posedge clk_8m) begin
    if (rst) begin
      r_addr_s1 <= '0;
      r_addr_s2 <= '0;
      r_data_s1 <= '0;
      r_data_s2 <= '0;
      // Strobe synchronizers clear to the idle (high) level so reset itself
      // never looks like a low phase.
      r_wr_n_s1 <= 1'b1;
      r_wr_n_s2 <= 1'b1;
    end else begin
      r_addr_s1 <= bus_addr;
      r_addr_s2 <= r_addr_s1;
      r_data_s1 <= bus_data;
      r_data_s2 <= r_data_s1;
      r_wr_n_s1 <= bus_wr_n;
      r_wr_n_s2 <= r_wr_n_s1;
    end
  end

  always_ff @(posedge clk_8m) begin
    if (rst) begin
      r_cnt       <= '0;
      r_hold_addr <= '0;
      r_hold_data <= '0;
    end else if (!r_wr_n_s2) begin
      if (r_cnt != 3'd7) begin
        r_cnt <= r_cnt + 3'd1;
      end
      r_hold_addr <= r_addr_s2;
      r_hold_data <= r_data_s2;
    end else begin
      r_cnt <= '0;
    end
  end

  // The counter is zero on every high cycle except the first one after a low
  // phase, so this fires once per qualifying strobe.
  assign w_commit = r_wr_n_s2 && (r_cnt >= FiltMin);
  assign w_dac_on = ({r_env_init, r_env_dir} != 5'd0);

  always_comb begin
    w_freq_d     = r_freq;
    w_start_d    = 1'b0;
    w_duty_d     = r_duty;
    w_env_init_d = r_env_init;
    w_env_dir_d  = r_env_dir;
    w_env_pace_d = r_env_pace;
    w_snd_on_d   = r_snd_on;

    if (w_commit) begin
      if (r_hold_addr == AddrNr52) begin
        w_snd_on_d = r_hold_data[7];
        // Power-off wipes the channel registers.
        if (r_snd_on && !r_hold_data[7]) begin
          w_freq_d     = '0;
          w_duty_d     = '0;
          w_env_init_d = '0;
          w_env_dir_d  = 1'b0;
          w_env_pace_d = '0;
        end
      end else if (r_snd_on) begin
        case (r_hold_addr)
          AddrNr11: w_duty_d = r_hold_data[7:6];
          AddrNr12: begin
            w_env_init_d = r_hold_data[7:4];
            w_env_dir_d  = r_hold_data[3];
            w_env_pace_d = r_hold_data[2:0];
          end
          AddrNr13: w_freq_d[7:0] = r_hold_data;
          AddrNr14: begin
            w_freq_d[10:8] = r_hold_data[2:0];
            w_start_d      = r_hold_data[7] && w_dac_on;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_8m) begin
    if (rst) begin
      r_freq     <= '0;
      r_start    <= 1'b0;
      r_duty     <= '0;
      r_env_init <= '0;
      r_env_dir  <= 1'b0;
      r_env_pace <= '0;
      r_snd_on   <= 1'b0;
    end else begin
      r_freq     <= w_freq_d;
      r_start    <= w_start_d;
      r_duty     <= w_duty_d;
      r_env_init <= w_env_init_d;
      r_env_dir  <= w_env_dir_d;
      r_env_pace <= w_env_pace_d;
      r_snd_on   <= w_snd_on_d;
    end
  end

  assign freq        = r_freq;
  assign start_sound = r_start;
  assign duty        = r_duty;
  assign env_init    = r_env_init;
  assign env_dir     = r_env_dir;
  assign env_pace    = r_env_pace;
  assign snd_on      = r_snd_on;

endmodule

// File: tb/tb_sndreg_snoop.sv
// Testbench for sndreg_snoop: table of directed writes, reset-mid-strobe
// sequence, then random writes checked against a register-level model.
module tb_sndreg_snoop;

  localparam int FILT = 2;

  logic        clk_8m = 1'b0;
  logic        rst;
  logic [15:0] bus_addr;
  logic [7:0]  bus_data;
  logic        bus_wr_n;
  logic [10:0] freq;
  logic        start_sound;
  logic [1:0]  duty;
  logic [3:0]  env_init;
  logic        env_dir;
  logic [2:0]  env_pace;
  logic        snd_on;

  sndreg_snoop #(.FILT_MIN(FILT)) dut (
    .clk_8m      (clk_8m),
    .rst         (rst),
    .bus_addr    (bus_addr),
    .bus_data    (bus_data),
    .bus_wr_n    (bus_wr_n),
    .freq        (freq),
    .start_sound (start_sound),
    .duty        (duty),
    .env_init    (env_init),
    .env_dir     (env_dir),
    .env_pace    (env_pace),
    .snd_on      (snd_on)
  );

  always #5 clk_8m = ~clk_8m;

  int total = 0;
  int bad   = 0;

  // Pulse monitor: counts high cycles of start_sound and records freq then.
  int          hi_cnt = 0;
  logic [10:0] pulse_freq = '0;
  always @(negedge clk_8m) begin
    if (start_sound) begin
      hi_cnt     = hi_cnt + 1;
      pulse_freq = freq;
    end
  end

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    int          low;
    logic [10:0] f;
    logic [1:0]  du;
    logic [3:0]  ei;
    logic        ed;
    logic [2:0]  ep;
    logic        on;
    int          pulses;
  } vec_t;

  vec_t tbl[$];

  // Model of the visible register state.
  logic [10:0] m_freq;
  logic [1:0]  m_duty;
  logic [3:0]  m_ei;
  logic        m_ed;
  logic [2:0]  m_ep;
  logic        m_on;

  function automatic vec_t mk(logic [15:0] a, logic [7:0] d, int low, logic [10:0] f,
                              logic [1:0] du, logic [3:0] ei, logic ed, logic [2:0] ep,
                              logic on, int p);
    vec_t v;
    v.addr = a; v.data = d; v.low = low; v.f = f; v.du = du; v.ei = ei; v.ed = ed;
    v.ep = ep; v.on = on; v.pulses = p;
    return v;
  endfunction

  function automatic logic [21:0] pk(logic [10:0] f, logic [1:0] du, logic [3:0] ei,
                                     logic ed, logic [2:0] ep, logic on);
    return {f, du, ei, ed, ep, on};
  endfunction

  function automatic logic [21:0] dut_state();
    return pk(freq, duty, env_init, env_dir, env_pace, snd_on);
  endfunction

  task automatic check(input string name, input logic [21:0] act, input logic [21:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One bus write with a low phase of `low` clocks, then idle time and garbage
  // on addr/data so only the held low-phase values can be committed.
  task automatic do_write(input logic [15:0] a, input logic [7:0] d, input int low);
    @(negedge clk_8m);
    bus_addr = a;
    bus_data = d;
    bus_wr_n = 1'b0;
    repeat (low) @(negedge clk_8m);
    bus_wr_n = 1'b1;
    repeat (2) @(negedge clk_8m);
    bus_addr = 16'($urandom);
    bus_data = 8'($urandom);
    repeat (5) @(negedge clk_8m);
  endtask

  // Spec rules applied to the model for one strobe; returns expected pulses.
  task automatic model_write(input logic [15:0] a, input logic [7:0] d, input int low,
                             output int p);
    p = 0;
    if (low < FILT) return;
    if (a == 16'hFF26) begin
      if (m_on && !d[7]) begin
        m_freq = 0; m_duty = 0; m_ei = 0; m_ed = 0; m_ep = 0;
      end
      m_on = d[7];
    end else if (m_on) begin
      if (a == 16'hFF11) m_duty = d[7:6];
      if (a == 16'hFF12) begin
        m_ei = d[7:4]; m_ed = d[3]; m_ep = d[2:0];
      end
      if (a == 16'hFF13) m_freq = {m_freq[10:8], d};
      if (a == 16'hFF14) begin
        if (d[7] && (m_ei != 0 || m_ed)) p = 1;
        m_freq = {d[2:0], m_freq[7:0]};
      end
    end
  endtask

  initial begin
    int h0;
    int p;
    logic [15:0] a;
    logic [7:0]  d;
    int          low;

    rst      = 1'b1;
    bus_addr = 16'hFF14;
    bus_data = 8'h87;
    bus_wr_n = 1'b1;
    repeat (3) @(negedge clk_8m);
    check("reset_state", dut_state(), 22'd0);
    check_int("reset_no_pulse", int'(start_sound), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk_8m);

    // addr, data, low clocks, expected freq, duty, env_init, env_dir, env_pace, snd_on, pulses
    tbl.push_back(mk(16'hFF26, 8'h80, 3, 11'h000, 2'd0, 4'h0, 1'b0, 3'd0, 1'b1, 0));
    tbl.push_back(mk(16'hFF12, 8'hF3, 3, 11'h000, 2'd0, 4'hF, 1'b0, 3'd3, 1'b1, 0));
    tbl.push_back(mk(16'hFF13, 8'h83, 3, 11'h083, 2'd0, 4'hF, 1'b0, 3'd3, 1'b1, 0));
    tbl.push_back(mk(16'hFF14, 8'h87, 3, 11'h783, 2'd0, 4'hF, 1'b0, 3'd3, 1'b1, 1));
    tbl.push_back(mk(16'hFF11, 8'hC0, 3, 11'h783, 2'd3, 4'hF, 1'b0, 3'd3, 1'b1, 0));
    tbl.push_back(mk(16'hFF14, 8'h02, 3, 11'h283, 2'd3, 4'hF, 1'b0, 3'd3, 1'b1, 0));
    tbl.push_back(mk(16'hFF12, 8'h00, 3, 11'h283, 2'd3, 4'h0, 1'b0, 3'd0, 1'b1, 0));
    tbl.push_back(mk(16'hFF14, 8'h87, 3, 11'h783, 2'd3, 4'h0, 1'b0, 3'd0, 1'b1, 0));
    tbl.push_back(mk(16'hFF13, 8'hC1, 1, 11'h783, 2'd3, 4'h0, 1'b0, 3'd0, 1'b1, 0));
    tbl.push_back(mk(16'hFF13, 8'hC1, 3, 11'h7C1, 2'd3, 4'h0, 1'b0, 3'd0, 1'b1, 0));
    tbl.push_back(mk(16'hFF12, 8'hA5, 3, 11'h7C1, 2'd3, 4'hA, 1'b0, 3'd5, 1'b1, 0));
    tbl.push_back(mk(16'hFF26, 8'h00, 3, 11'h000, 2'd0, 4'h0, 1'b0, 3'd0, 1'b0, 0));
    tbl.push_back(mk(16'hFF14, 8'h87, 3, 11'h000, 2'd0, 4'h0, 1'b0, 3'd0, 1'b0, 0));
    tbl.push_back(mk(16'hFF12, 8'hF3, 3, 11'h000, 2'd0, 4'h0, 1'b0, 3'd0, 1'b0, 0));
    tbl.push_back(mk(16'hFF26, 8'h80, 3, 11'h000, 2'd0, 4'h0, 1'b0, 3'd0, 1'b1, 0));
    tbl.push_back(mk(16'hFF12, 8'hF3, 3, 11'h000, 2'd0, 4'hF, 1'b0, 3'd3, 1'b1, 0));
    tbl.push_back(mk(16'hFF10, 8'hFF, 3, 11'h000, 2'd0, 4'hF, 1'b0, 3'd3, 1'b1, 0));
    tbl.push_back(mk(16'hFF15, 8'hFF, 3, 11'h000, 2'd0, 4'hF, 1'b0, 3'd3, 1'b1, 0));
    tbl.push_back(mk(16'hFE14, 8'hFF, 3, 11'h000, 2'd0, 4'hF, 1'b0, 3'd3, 1'b1, 0));
    tbl.push_back(mk(16'hFF12, 8'h08, 2, 11'h000, 2'd0, 4'h0, 1'b1, 3'd0, 1'b1, 0));
    tbl.push_back(mk(16'hFF14, 8'h81, 2, 11'h100, 2'd0, 4'h0, 1'b1, 3'd0, 1'b1, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      h0 = hi_cnt;
      do_write(tbl[i].addr, tbl[i].data, tbl[i].low);
      check($sformatf("vec%0d_regs", i), dut_state(),
            pk(tbl[i].f, tbl[i].du, tbl[i].ei, tbl[i].ed, tbl[i].ep, tbl[i].on));
      check_int($sformatf("vec%0d_pulses", i), hi_cnt - h0, tbl[i].pulses);
      if (tbl[i].pulses == 1) begin
        check($sformatf("vec%0d_pulse_freq", i), {11'd0, pulse_freq}, {11'd0, tbl[i].f});
      end
    end

    // Reset asserted mid-strobe on a triggering FF14 write.
    h0 = hi_cnt;
    @(negedge clk_8m);
    bus_addr = 16'hFF14;
    bus_data = 8'h87;
    bus_wr_n = 1'b0;
    repeat (3) @(negedge clk_8m);
    rst = 1'b1;
    repeat (2) @(negedge clk_8m);
    check("rst_mid_during", dut_state(), 22'd0);
    rst = 1'b0;
    @(negedge clk_8m);
    bus_wr_n = 1'b1;
    repeat (8) @(negedge clk_8m);
    check("rst_mid_after", dut_state(), 22'd0);
    check_int("rst_mid_pulses", hi_cnt - h0, 0);

    // Random writes against the model, starting from reset state.
    m_freq = 0; m_duty = 0; m_ei = 0; m_ed = 0; m_ep = 0; m_on = 0;
    for (int n = 0; n < 120; n++) begin
      case ($urandom_range(0, 9))
        0: a = 16'hFF10;
        1: a = 16'hFF11;
        2: a = 16'hFF12;
        3: a = 16'hFF13;
        4, 5: a = 16'hFF14;
        6: a = 16'hFF15;
        7: a = 16'hFF26;
        8: a = 16'hFE14;
        default: a = 16'($urandom);
      endcase
      d   = 8'($urandom);
      low = $urandom_range(1, 4);
      if (a == 16'hFF26 && $urandom_range(0, 3) != 0) d[7] = 1'b1;
      h0 = hi_cnt;
      do_write(a, d, low);
      model_write(a, d, low, p);
      check($sformatf("rnd%0d_regs a=%h d=%h l=%0d", n, a, d, low), dut_state(),
            pk(m_freq, m_duty, m_ei, m_ed, m_ep, m_on));
      check_int($sformatf("rnd%0d_pulses", n), hi_cnt - h0, p);
      if (p == 1) check($sformatf("rnd%0d_pulse_freq", n), {11'd0, pulse_freq}, {11'd0, m_freq});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
